// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with fill counter, programmable almost-full/empty thresholds and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise rdata is registered (1-cycle latency).
module sync_fifo_prog #(
   parameter int DATA_LINES = 8,
   parameter int ADDR_LINES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  winc,
   input  logic [DATA_LINES-1:0] wdata,
   input  logic                  rinc,
   output logic [DATA_LINES-1:0] rdata,
   input  logic [ADDR_LINES:0]   af_thresh,
   input  logic [ADDR_LINES:0]   ae_thresh,
   input  logic                  err_clr,
   output logic [ADDR_LINES:0]   fill_count,
   output logic                  wfull,
   output logic                  rempty,
   output logic                  half_full,
   output logic                  half_empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_LINES;
   localparam logic [ADDR_LINES:0] C_DEPTH = (ADDR_LINES+1)'(DEPTH);
   localparam logic [ADDR_LINES:0] C_HALF  = (ADDR_LINES+1)'(DEPTH / 2);

   logic [DATA_LINES-1:0] r_mem [DEPTH];
   logic [ADDR_LINES-1:0] r_wrAddr;
   logic [ADDR_LINES-1:0] r_rdAddr;
   logic [ADDR_LINES:0]   r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_full;
   logic w_empty;
   logic w_wrAcc;
   logic w_rdAcc;

   // Acceptance depends only on the registered count, so a full FIFO can still take a read
   // and an empty one a write in the same cycle.
   assign w_full  = (r_count == C_DEPTH);
   assign w_empty = (r_count == '0);
   assign w_wrAcc = winc && !w_full;
   assign w_rdAcc = rinc && !w_empty;

   always_ff @(posedge clk) begin
      if (w_wrAcc) begin
         r_mem[r_wrAddr] <= wdata;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrAddr <= '0;
         r_rdAddr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wrAcc) begin
            r_wrAddr <= r_wrAddr + 1'b1;
         end
         if (w_rdAcc) begin
            r_rdAddr <= r_rdAddr + 1'b1;
         end
         case ({w_wrAcc, w_rdAcc})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // A rejecting access in the same cycle as err_clr wins, so no error event is ever lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (winc && w_full) begin
            r_overflow <= 1'b1;
         end else if (err_clr) begin
            r_overflow <= 1'b0;
         end
         if (rinc && w_empty) begin
            r_underflow <= 1'b1;
         end else if (err_clr) begin
            r_underflow <= 1'b0;
         end
      end
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign rdata = r_mem[r_rdAddr];
`else
   logic [DATA_LINES-1:0] r_rdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (w_rdAcc) begin
         r_rdata <= r_mem[r_rdAddr];
      end
   end

   assign rdata = r_rdata;
`endif

   // Threshold extremes need no special casing: af_thresh=0 and ae_thresh>=DEPTH saturate naturally.
   assign fill_count   = r_count;
   assign wfull        = w_full;
   assign rempty       = w_empty;
   assign half_full    = (r_count >= C_HALF);
   assign half_empty   = (r_count <  C_HALF);
   assign almost_full  = (r_count >= af_thresh);
   assign almost_empty = (r_count <= ae_thresh);
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: directed scenarios plus randomized traffic against a queue model.
// Honours SYNC_FIFO_FWFT_EN to pick the expected rdata behaviour.
module tb_sync_fifo_prog;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       winc = 1'b0;
   logic       rinc = 1'b0;
   logic       errClr = 1'b0;
   logic [7:0] wdata = 8'h00;
   logic [4:0] afThresh = 5'd12;
   logic [4:0] aeThresh = 5'd3;

   logic [7:0] rdata;
   logic [4:0] fillCount;
   logic       wfull, rempty, halfFull, halfEmpty, almostFull, almostEmpty, overflow, underflow;
   logic [7:0] obsFlags;

   int total = 0;
   int bad = 0;

   logic [7:0] modelQ[$];
   logic [7:0] modelRdata = 8'h00;
   logic       modelOvf = 1'b0;
   logic       modelUnf = 1'b0;

   sync_fifo_prog #(.DATA_LINES(8), .ADDR_LINES(4)) dut (
      .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
      .af_thresh(afThresh), .ae_thresh(aeThresh), .err_clr(errClr), .fill_count(fillCount),
      .wfull(wfull), .rempty(rempty), .half_full(halfFull), .half_empty(halfEmpty),
      .almost_full(almostFull), .almost_empty(almostEmpty), .overflow(overflow), .underflow(underflow)
   );

   assign obsFlags = {wfull, rempty, halfFull, halfEmpty, almostFull, almostEmpty, overflow, underflow};

   always #5 clk = ~clk;

   // Reference model: a plain queue plus sticky bits, updated once per rising edge.
   task automatic modelReset();
      modelQ.delete();
      modelRdata = 8'h00;
      modelOvf = 1'b0;
      modelUnf = 1'b0;
   endtask

   task automatic modelStep(input logic w, input logic [7:0] wd, input logic r, input logic ec);
      int n;
      n = modelQ.size();
      if (r && n > 0) modelRdata = modelQ.pop_front();
      if (w && n < DEPTH) modelQ.push_back(wd);
      if (w && n == DEPTH) modelOvf = 1'b1;
      else if (ec) modelOvf = 1'b0;
      if (r && n == 0) modelUnf = 1'b1;
      else if (ec) modelUnf = 1'b0;
   endtask

   function automatic logic [7:0] expFlags();
      int n;
      n = modelQ.size();
      return {n == DEPTH, n == 0, n >= DEPTH/2, n < DEPTH/2,
              n >= int'(afThresh), n <= int'(aeThresh), modelOvf, modelUnf};
   endfunction

   function automatic bit rdValid();
`ifdef SYNC_FIFO_FWFT_EN
      return modelQ.size() != 0;
`else
      return 1'b1;
`endif
   endfunction

   function automatic logic [7:0] rdExp();
`ifdef SYNC_FIFO_FWFT_EN
      return (modelQ.size() != 0) ? modelQ[0] : 8'h00;
`else
      return modelRdata;
`endif
   endfunction

   // Drive one clock's worth of requests, advance the model at the edge, then release the strobes.
   task automatic doCycle(input logic w, input logic [7:0] wd, input logic r, input logic ec);
      winc = w;
      wdata = wd;
      rinc = r;
      errClr = ec;
      @(posedge clk);
      modelStep(w, wd, r, ec);
      #1;
      winc = 1'b0;
      rinc = 1'b0;
      errClr = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      total++;
      if (fillCount !== 5'd0) begin bad++; $display("[TB] FAIL reset_count: got %0d want 0", fillCount); end
      total++;
      if (obsFlags !== 8'b0101_0100) begin bad++; $display("[TB] FAIL reset_flags: got %b want 01010100", obsFlags); end
`ifndef SYNC_FIFO_FWFT_EN
      total++;
      if (rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %h want 00", rdata); end
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      modelReset();
   endtask

   task automatic test_fill_overflow();
      for (int i = 0; i < DEPTH; i++) begin
         doCycle(1'b1, 8'(i), 1'b0, 1'b0);
         total++;
         if (fillCount !== 5'(i + 1)) begin bad++; $display("[TB] FAIL fill_count: got %0d want %0d", fillCount, i + 1); end
         total++;
         if (halfFull !== (i + 1 >= 8)) begin bad++; $display("[TB] FAIL fill_half_full: got %b want %b at %0d", halfFull, (i + 1 >= 8), i + 1); end
         total++;
         if (wfull !== (i == DEPTH - 1)) begin bad++; $display("[TB] FAIL fill_wfull: got %b want %b at %0d", wfull, (i == DEPTH - 1), i + 1); end
      end
      doCycle(1'b1, 8'hEE, 1'b0, 1'b0);
      total++;
      if (overflow !== 1'b1 || fillCount !== 5'd16) begin
         bad++; $display("[TB] FAIL overflow_set: got ovf=%b cnt=%0d want ovf=1 cnt=16", overflow, fillCount);
      end
   endtask

   task automatic test_drain_underflow();
      for (int i = 0; i < DEPTH; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
         total++;
         if (rdata !== 8'(i)) begin bad++; $display("[TB] FAIL drain_data: got %h want %h", rdata, 8'(i)); end
         doCycle(1'b0, 8'h00, 1'b1, 1'b0);
`else
         doCycle(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (rdata !== 8'(i)) begin bad++; $display("[TB] FAIL drain_data: got %h want %h", rdata, 8'(i)); end
`endif
         total++;
         if (obsFlags !== expFlags()) begin bad++; $display("[TB] FAIL drain_flags: got %b want %b", obsFlags, expFlags()); end
      end
      total++;
      if (rempty !== 1'b1) begin bad++; $display("[TB] FAIL drain_empty: got %b want 1", rempty); end
      doCycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL underflow_set: got %b want 1", underflow); end
`ifndef SYNC_FIFO_FWFT_EN
      total++;
      if (rdata !== 8'h0F) begin bad++; $display("[TB] FAIL underflow_rdata_hold: got %h want 0f", rdata); end
`endif
      doCycle(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if ({overflow, underflow} !== 2'b00) begin bad++; $display("[TB] FAIL err_clear_both: got %b want 00", {overflow, underflow}); end
   endtask

   task automatic test_thresholds();
      afThresh = 5'd12;
      aeThresh = 5'd3;
      for (int i = 1; i <= 12; i++) begin
         doCycle(1'b1, 8'($urandom), 1'b0, 1'b0);
         total++;
         if (almostFull !== (i >= 12)) begin bad++; $display("[TB] FAIL almost_full_rise: got %b want %b at %0d", almostFull, (i >= 12), i); end
      end
      for (int i = 11; i >= 3; i--) begin
         doCycle(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (almostEmpty !== (i <= 3)) begin bad++; $display("[TB] FAIL almost_empty_rise: got %b want %b at %0d", almostEmpty, (i <= 3), i); end
         total++;
         if (rdValid() && rdata !== rdExp()) begin bad++; $display("[TB] FAIL thresh_data: got %h want %h", rdata, rdExp()); end
      end
      while (modelQ.size() > 0) doCycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (fillCount !== 5'd0) begin bad++; $display("[TB] FAIL thresh_drain: got %0d want 0", fillCount); end
   endtask

   task automatic test_simultaneous();
      doCycle(1'b1, 8'h31, 1'b1, 1'b0);
      total++;
      if (fillCount !== 5'd1) begin bad++; $display("[TB] FAIL simul_empty: got %0d want 1", fillCount); end
      repeat (4) doCycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      doCycle(1'b1, 8'h55, 1'b1, 1'b0);
      total++;
      if (fillCount !== 5'd5) begin bad++; $display("[TB] FAIL simul_mid: got %0d want 5", fillCount); end
      total++;
      if (rdValid() && rdata !== rdExp()) begin bad++; $display("[TB] FAIL simul_mid_data: got %h want %h", rdata, rdExp()); end
      while (modelQ.size() < DEPTH) doCycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      doCycle(1'b1, 8'hAA, 1'b1, 1'b0);
      total++;
      if (fillCount !== 5'd15) begin bad++; $display("[TB] FAIL simul_full: got %0d want 15", fillCount); end
      total++;
      if (obsFlags !== expFlags()) begin bad++; $display("[TB] FAIL simul_flags: got %b want %b", obsFlags, expFlags()); end
      doCycle(1'b0, 8'h00, 1'b0, 1'b1);
      while (modelQ.size() > 0) begin
         doCycle(1'b0, 8'h00, 1'b1, 1'b0);
         total++;
         if (rdValid() && rdata !== rdExp()) begin bad++; $display("[TB] FAIL simul_order: got %h want %h", rdata, rdExp()); end
      end
   endtask

   task automatic test_err_clear();
      while (modelQ.size() < DEPTH) doCycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      doCycle(1'b1, 8'h77, 1'b0, 1'b0);
      doCycle(1'b1, 8'h78, 1'b0, 1'b1);
      total++;
      if (overflow !== 1'b1) begin bad++; $display("[TB] FAIL err_set_priority: got %b want 1", overflow); end
      doCycle(1'b0, 8'h00, 1'b0, 1'b1);
      total++;
      if (overflow !== 1'b0) begin bad++; $display("[TB] FAIL err_clr_alone: got %b want 0", overflow); end
      while (modelQ.size() > 0) doCycle(1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   task automatic test_async_reset();
      repeat (9) doCycle(1'b1, 8'($urandom), 1'b0, 1'b0);
      total++;
      if (fillCount !== 5'd9) begin bad++; $display("[TB] FAIL pre_reset_count: got %0d want 9", fillCount); end
      winc = 1'b1;
      wdata = 8'hC3;
      #3 rst = 1'b1;
      #1;
      modelReset();
      total++;
      if (fillCount !== 5'd0) begin bad++; $display("[TB] FAIL async_count: got %0d want 0", fillCount); end
      total++;
      if (obsFlags !== expFlags()) begin bad++; $display("[TB] FAIL async_flags: got %b want %b", obsFlags, expFlags()); end
`ifndef SYNC_FIFO_FWFT_EN
      total++;
      if (rdata !== 8'h00) begin bad++; $display("[TB] FAIL async_rdata: got %h want 00", rdata); end
`endif
      @(posedge clk);
      #1 rst = 1'b0;
      winc = 1'b0;
      total++;
      if (fillCount !== 5'd0) begin bad++; $display("[TB] FAIL reset_ignores_req: got %0d want 0", fillCount); end
      doCycle(1'b1, 8'h5A, 1'b0, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
      total++;
      if (rdata !== 8'h5A) begin bad++; $display("[TB] FAIL post_reset_data: got %h want 5a", rdata); end
      doCycle(1'b0, 8'h00, 1'b1, 1'b0);
`else
      doCycle(1'b0, 8'h00, 1'b1, 1'b0);
      total++;
      if (rdata !== 8'h5A) begin bad++; $display("[TB] FAIL post_reset_data: got %h want 5a", rdata); end
`endif
   endtask

   task automatic test_random_mix();
      int wPct;
      logic w, r, ec;
      for (int c = 0; c < 360; c++) begin
         wPct = (c < 120) ? 75 : (c < 240) ? 25 : 50;
         w = ($urandom_range(0, 99) < wPct);
         r = ($urandom_range(0, 99) < 100 - wPct);
         ec = ($urandom_range(0, 19) == 0);
         if ($urandom_range(0, 39) == 0) begin
            afThresh = 5'($urandom_range(0, 17));
            aeThresh = 5'($urandom_range(0, 17));
            #1;
         end
         doCycle(w, 8'($urandom), r, ec);
         total++;
         if (fillCount !== 5'(modelQ.size())) begin bad++; $display("[TB] FAIL rand_count: got %0d want %0d", fillCount, modelQ.size()); end
         total++;
         if (obsFlags !== expFlags()) begin bad++; $display("[TB] FAIL rand_flags: got %b want %b", obsFlags, expFlags()); end
         if (rdValid()) begin
            total++;
            if (rdata !== rdExp()) begin bad++; $display("[TB] FAIL rand_rdata: got %h want %h", rdata, rdExp()); end
         end
      end
   endtask

   initial begin
      modelReset();
      test_reset();
      test_fill_overflow();
      test_drain_underflow();
      test_thresholds();
      test_simultaneous();
      test_err_clear();
      test_async_reset();
      test_random_mix();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock, parametrised FIFO with a fill-level counter, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the single-clock successor to our dual-clock FIFO and keeps the same write/read strobe and status-flag naming. It buffers data between producer and consumer logic inside one clock domain, where pointer synchronisers are unnecessary. First-word-fall-through read mode is a compile-time option.

## Interface
- DATA_LINES, 8, data word width in bits
- ADDR_LINES, 4, address width; DEPTH = 2**ADDR_LINES words (ADDR_LINES ≥ 2)
- clk  input  1  single clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- winc  input  1  write request
- wdata  input  DATA_LINES  write data, sampled with winc
- rinc  input  1  read request
- rdata  output  DATA_LINES  read data
- af_thresh  input  ADDR_LINES+1  almost-full threshold (quasi-static)
- ae_thresh  input  ADDR_LINES+1  almost-empty threshold (quasi-static)
- err_clr  input  1  clears overflow and underflow
- fill_count  output  ADDR_LINES+1  words currently stored, 0..DEPTH
- wfull, rempty  output  1  full (count==DEPTH), empty (count==0)
- half_full, half_empty  output  1  count ≥ DEPTH/2, count < DEPTH/2
- almost_full, almost_empty  output  1  count ≥ af_thresh, count ≤ ae_thresh
- overflow, underflow  output  1  sticky error flags

## Operation
- Storage: DEPTH×DATA_LINES array; waddr/raddr are ADDR_LINES-bit pointers wrapping DEPTH-1 → 0; count register ADDR_LINES+1 bits.
- Write accepted iff winc && !wfull. Data goes to mem[waddr], and waddr increments.
- Read accepted iff rinc && !rempty. raddr increments.
- Flags are evaluated on the registered count at the start of the cycle. Simultaneous winc+rinc when full: read accepted, write rejected, and count becomes DEPTH-1. When empty: write accepted, read rejected, and count becomes 1. Otherwise both are accepted and count is unchanged.
- Count update: +1 for a write alone, −1 for a read alone, 0 for both or neither. Count never wraps.
- All status outputs decode the registered count. There is no combinational path from winc/rinc to any flag.
- The threshold compares are unsigned, at ADDR_LINES+1 width. af_thresh=0 forces almost_full high. ae_thresh ≥ DEPTH forces almost_empty high.
- overflow sets on a rejected write (winc && wfull). underflow sets on a rejected read (rinc && rempty). err_clr clears both. A set takes priority over err_clr in the same cycle.
- A rejected access does not change memory, pointers, count or rdata.
- Reset clears waddr, raddr, count, rdata (to 0), overflow and underflow. The memory array is not reset.
- Output values in reset: rempty=1, half_empty=1, wfull=0, half_full=0, fill_count=0. almost_full and almost_empty follow the thresholds against count 0.

## Timing
- Write accepted at edge N: fill_count, rempty and the other flags reflect it after edge N.
- Default mode: a read accepted at edge N loads rdata ← mem[raddr] at edge N. rdata is valid after edge N and holds until the next accepted read. Read latency is 1 cycle.
- A word written at edge N is readable via rinc no earlier than the cycle after edge N.
- A write and a read to the same address in the same cycle cannot occur, because the count guarantees separation.
- rst asserted mid-operation: all registers clear immediately and asynchronously. Deassertion is synchronous to clk, external to this block. Pending requests during reset are ignored.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode. rdata = mem[raddr] combinationally whenever rempty=0. rinc acknowledges and pops the presented word. A word written at edge N appears on rdata after edge N with zero read latency. rdata is don't-care while rempty=1.
- SYNC_FIFO_FWFT_EN undefined: the registered read described under Timing.

## Test plan
- ADDR_LINES=4. Reset, then 16 writes of 0x00..0x0F → wfull=1 after the 16th edge, fill_count=16, half_full=1 from the 8th write. A 17th write → overflow=1, contents unchanged.
- From full, 16 reads → rdata sequence 0x00..0x0F, each 1 cycle after its rinc (FWFT: present before rinc). Then rempty=1. An extra rinc → underflow=1, rdata holds 0x0F.
- af_thresh=12, ae_thresh=3: fill to 12 → almost_full rises on the 12th write edge. Drain to 3 → almost_empty rises on that read edge.
- Simultaneous winc+rinc at count 0, 5 and 16 → count becomes 1, stays 5, and becomes 15 respectively. Data order is preserved across the pointer wrap after 40 mixed operations.
- overflow set, then err_clr pulsed in the same cycle as another rejected write → overflow stays 1. err_clr alone next cycle → 0.
- Assert rst asynchronously mid-burst with count=9 → all outputs return to reset values before the next clk edge. After release, the first write/read returns the new data, not stale data.
